// File: rtl/ldst_ctrl_pkg.sv
// Shared state codes, opcode values and helpers for the ld/ldi/st control sequencer.
package ldst_ctrl_pkg;

  // State codes double as the tstate debug value.
  localparam logic [3:0] ST_RESET = 4'd0;
  localparam logic [3:0] ST_T0    = 4'd1;
  localparam logic [3:0] ST_T1    = 4'd2;
  localparam logic [3:0] ST_T2    = 4'd3;
  localparam logic [3:0] ST_T3    = 4'd4;
  localparam logic [3:0] ST_T4    = 4'd5;
  localparam logic [3:0] ST_T5    = 4'd6;
  localparam logic [3:0] ST_T6    = 4'd7;
  localparam logic [3:0] ST_T7    = 4'd8;
  localparam logic [3:0] ST_DEC   = 4'd9;
  localparam logic [3:0] ST_HALT  = 4'd15;

  localparam logic [4:0] OPC_LD   = 5'b00000;
  localparam logic [4:0] OPC_LDI  = 5'b00001;
  localparam logic [4:0] OPC_ST   = 5'b00010;
  localparam logic [4:0] OPC_NOP  = 5'b11010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  typedef enum logic [1:0] {
    KIND_LD   = 2'd0,
    KIND_LDI  = 2'd1,
    KIND_ST   = 2'd2,
    KIND_NONE = 2'd3
  } op_kind_t;

  function automatic int wait_cnt_w(input int mem_wait);
    return (mem_wait < 1) ? 1 : $clog2(mem_wait + 1);
  endfunction

endpackage

// File: rtl/ldst_control_unit_mem_wait_counter.sv
// Memory wait-state counter: cleared by load, counts up while enabled, done at MEM_WAIT.
module mem_wait_counter
  import ldst_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done,
  output logic first
);

  localparam int CW = wait_cnt_w(MEM_WAIT);
  localparam logic [CW-1:0] LAST = CW'(MEM_WAIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= '0;
    else if (en && !done)
      cnt <= cnt + CW'(1);
  end

  assign done  = (cnt == LAST);
  assign first = (cnt == '0);

endmodule

// File: rtl/ldst_control_unit.sv
// Moore control sequencer: fetch T0-T2, DEC, then ld/ldi/st execute steps with stop/start handshake.
// Optional LDST_ILLEGAL_TRAP_EN: unknown opcodes halt and raise a sticky illegal flag.
module ldst_control_unit
  import ldst_ctrl_pkg::*;
#(
  parameter int                     OPCODE_W = 5,
  parameter int                     MEM_WAIT = 0,
  parameter logic [OPCODE_W-1:0]    OP_LD    = OPCODE_W'(OPC_LD),
  parameter logic [OPCODE_W-1:0]    OP_LDI   = OPCODE_W'(OPC_LDI),
  parameter logic [OPCODE_W-1:0]    OP_ST    = OPCODE_W'(OPC_ST),
  parameter logic [OPCODE_W-1:0]    OP_NOP   = OPCODE_W'(OPC_NOP),
  parameter logic [OPCODE_W-1:0]    OP_HALT  = OPCODE_W'(OPC_HALT)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                Start,
  input  logic                Stop,
  output logic                Run,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                Zin,
  output logic                ZLOout,
  output logic                PCin,
  output logic                Read,
  output logic                write,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Gra,
  output logic                Grb,
  output logic                Rin,
  output logic                Rout,
  output logic                BAout,
  output logic                Yin,
  output logic                Cout,
  output logic                ADD,
  output logic [3:0]          tstate
`ifdef LDST_ILLEGAL_TRAP_EN
  ,
  output logic                illegal
`endif
);

  logic [3:0] state, state_nxt;
  op_kind_t   kind, kind_nxt;
  logic       stop_pend;
  logic       end_instr;
  logic       wc_load, wc_en, wc_done, wc_first;
`ifdef LDST_ILLEGAL_TRAP_EN
  logic       trap;
`endif

  assign wc_load = (state == ST_T0) || (state == ST_T5);
  assign wc_en   = (state == ST_T1) || (state == ST_T6);

  mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk  (Clock),
    .rst  (Reset),
    .load (wc_load),
    .en   (wc_en),
    .done (wc_done),
    .first(wc_first)
  );

  always_comb begin
    state_nxt = state;
    kind_nxt  = kind;
    end_instr = 1'b0;
`ifdef LDST_ILLEGAL_TRAP_EN
    trap      = 1'b0;
`endif
    case (state)
      ST_RESET: state_nxt = ST_T0;
      ST_T0:    state_nxt = ST_T1;
      ST_T1:    if (wc_done) state_nxt = ST_T2;
      ST_T2:    state_nxt = ST_DEC;
      ST_DEC: begin
        if (opcode == OP_LD) begin
          kind_nxt  = KIND_LD;
          state_nxt = ST_T3;
        end else if (opcode == OP_LDI) begin
          kind_nxt  = KIND_LDI;
          state_nxt = ST_T3;
        end else if (opcode == OP_ST) begin
          kind_nxt  = KIND_ST;
          state_nxt = ST_T3;
        end else if (opcode == OP_HALT) begin
          kind_nxt  = KIND_NONE;
          state_nxt = ST_HALT;
        end else if (opcode == OP_NOP) begin
          kind_nxt  = KIND_NONE;
          end_instr = 1'b1;
        end else begin
          kind_nxt  = KIND_NONE;
`ifdef LDST_ILLEGAL_TRAP_EN
          trap      = 1'b1;
          state_nxt = ST_HALT;
`else
          end_instr = 1'b1;
`endif
        end
      end
      ST_T3: state_nxt = ST_T4;
      ST_T4: state_nxt = ST_T5;
      ST_T5: begin
        if (kind == KIND_LDI) end_instr = 1'b1;
        else                  state_nxt = ST_T6;
      end
      ST_T6: if (kind != KIND_LD || wc_done) state_nxt = ST_T7;
      ST_T7: end_instr = 1'b1;
      ST_HALT: if (Start) state_nxt = ST_T0;
      default: state_nxt = ST_RESET;
    endcase
    // A Stop arriving in the final step still counts toward this boundary.
    if (end_instr)
      state_nxt = (stop_pend || Stop) ? ST_HALT : ST_T0;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= ST_RESET;
      kind      <= KIND_NONE;
      stop_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      kind  <= kind_nxt;
      if (state_nxt == ST_HALT)
        stop_pend <= 1'b0;
      else if (Stop && Run)
        stop_pend <= 1'b1;
    end
  end

`ifdef LDST_ILLEGAL_TRAP_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      illegal <= 1'b0;
    else if (trap)
      illegal <= 1'b1;
    else if (state == ST_HALT && Start)
      illegal <= 1'b0;
  end
`endif

  always_comb begin
    Run    = (state != ST_RESET) && (state != ST_HALT);
    tstate = state;
    PCout  = 1'b0;
    MARin  = 1'b0;
    IncPC  = 1'b0;
    Zin    = 1'b0;
    ZLOout = 1'b0;
    PCin   = 1'b0;
    Read   = 1'b0;
    write  = 1'b0;
    MDRin  = 1'b0;
    MDRout = 1'b0;
    IRin   = 1'b0;
    Gra    = 1'b0;
    Grb    = 1'b0;
    Rin    = 1'b0;
    Rout   = 1'b0;
    BAout  = 1'b0;
    Yin    = 1'b0;
    Cout   = 1'b0;
    ADD    = 1'b0;
    case (state)
      ST_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      ST_T1: begin
        Read   = 1'b1;
        ZLOout = wc_first;
        PCin   = wc_first;
        MDRin  = wc_done;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        Grb   = 1'b1;
        BAout = 1'b1;
        Yin   = 1'b1;
      end
      ST_T4: begin
        Cout = 1'b1;
        ADD  = 1'b1;
        Zin  = 1'b1;
      end
      ST_T5: begin
        ZLOout = 1'b1;
        if (kind == KIND_LDI) begin
          Gra = 1'b1;
          Rin = 1'b1;
        end else begin
          MARin = 1'b1;
        end
      end
      ST_T6: begin
        if (kind == KIND_ST) begin
          Gra   = 1'b1;
          Rout  = 1'b1;
          MDRin = 1'b1;
        end else begin
          Read  = 1'b1;
          MDRin = wc_done;
        end
      end
      ST_T7: begin
        MDRout = 1'b1;
        if (kind == KIND_ST) begin
          write = 1'b1;
        end else begin
          Gra = 1'b1;
          Rin = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/ldst_control_unit.md
Name: ldst_control_unit

Overview:
- Hardwired Moore control sequencer for the datapath.
- Replaces hand-driven control strobes with an FSM. Runs fetch (T0–T2) followed by the execute steps for ld, ldi, st, nop and halt.
- Parametrised memory wait states and a stop/start run handshake. Sits beside the datapath; consumes IR opcode bits, drives every datapath strobe.

Parameters:
- OPCODE_W, 5, opcode field width (IR[31:27]).
- MEM_WAIT, 0, extra cycles Read is held before MDRin is pulsed; legal 0..15.
- OP_LD, 5'b00000, ld opcode.
- OP_LDI, 5'b00001, ldi opcode.
- OP_ST, 5'b00010, st opcode.
- OP_NOP, 5'b11010, nop opcode.
- OP_HALT, 5'b11011, halt opcode.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- opcode  in  OPCODE_W  IR[31:27]; sampled in T3-entry decode only.
- Start  in  1  sync pulse; leaves HALT.
- Stop  in  1  sync pulse; requests halt at instruction boundary.
- Run  out  1  high except in RESET/HALT.
- PCout, MARin, IncPC, Zin, ZLOout, PCin, Read, write, MDRin, MDRout, IRin  out  1 each  datapath strobes.
- Gra, Grb, Rin, Rout, BAout, Yin, Cout, ADD  out  1 each  register-select / ALU strobes.
- tstate  out  4  debug state code.

Behaviour:
- Reset:
  - Asynchronous; forces state RESET. All strobes, Run, the wait counter and stop_pend clear immediately.
  - RESET lasts 1 cycle after Reset deasserts, then T0.
- Output decoding: all outputs are a decode of the state register only (Moore). A state with no listed strobes drives all strobes 0.
- Fetch:
  - T0: PCout MARin IncPC Zin.
  - T1: Read; ZLOout PCin on the first T1 cycle only. T1 persists MEM_WAIT+1 cycles; MDRin is asserted on the final cycle only.
  - T2: MDRout IRin.
- Decode at end of T2 (opcode is valid one cycle after IRin):
  - Decode is a one-cycle state DEC with no strobes.
  - ld/ldi/st → T3. nop → T0 (or HALT if stop_pend). halt → HALT.
  - Any other opcode is handled as nop.
- ld:
  - T3: Grb BAout Yin.
  - T4: Cout ADD Zin.
  - T5: ZLOout MARin.
  - T6: Read for MEM_WAIT+1 cycles; MDRin on the last cycle.
  - T7: MDRout Gra Rin.
- ldi: T3 and T4 as ld; T5: ZLOout Gra Rin; end.
- st: T3–T5 as ld; T6: Gra Rout MDRin; T7: MDRout write.
- Cycle counts (Reset-free, incl. DEC):
  - ld: 9+2·MEM_WAIT.
  - ldi: 7+MEM_WAIT.
  - st: 9+MEM_WAIT.
  - nop: 4+MEM_WAIT.
- Wait counter: width max(1,$clog2(MEM_WAIT+1)). It loads 0 on entering T1/T6, increments each cycle, and exits when it equals MEM_WAIT. With MEM_WAIT=0, T1 is a single cycle carrying ZLOout PCin Read MDRin.
- Stop:
  - A Stop pulse in any state except HALT/RESET sets stop_pend.
  - At the last state of an instruction, stop_pend → HALT (cleared on entry); otherwise → T0.
- HALT:
  - Run=0, all strobes 0.
  - Start → T0 next cycle. Start and Stop in the same HALT cycle: Start wins. Start outside HALT is ignored.
- Reset mid-instruction: aborts immediately. No partial strobe survives past Reset assertion.
- tstate encoding: RESET=0, T0..T7=1..8, DEC=9, HALT=15.

Optional Feature:
- Macro: LDST_ILLEGAL_TRAP_EN.
- Defined:
  - Unknown opcodes go to HALT rather than being handled as nop.
  - Sticky output illegal (1 bit) sets on that event and clears on Reset or Start.
- Undefined: unknown opcodes behave as nop; the illegal port is absent.

Decomposition:
- Package ldst_ctrl_pkg holds:
  - state enum/localparams (RESET, T0..T7, DEC, HALT) with their tstate codes;
  - opcode localparams.
- Sub-module mem_wait_counter: parametrised MEM_WAIT, inputs load/en, output done.
- The FSM and output decode stay in ldst_control_unit.

Test Plan:
- Reset asserted in T5 of ld → all strobes 0 within the same time step. Release → RESET for 1 cycle, then T0 (tstate 0→1).
- MEM_WAIT=0, opcode=OP_LD → 9-cycle sequence. Check exact strobe vector per T state; T1 = {ZLOout,PCin,Read,MDRin}; T7 = {MDRout,Gra,Rin}.
- MEM_WAIT=2, opcode=OP_LD:
  - T1 and T6 each last 3 cycles with Read high throughout.
  - MDRin only on the 3rd cycle.
  - ZLOout/PCin only on the 1st T1 cycle.
  - Total 13 cycles.
- MEM_WAIT=0, opcode=OP_ST → T6 {Gra,Rout,MDRin}, T7 {MDRout,write}. Read never high after T1; total 9 cycles.
- Stop pulse during T4 of ldi → instruction completes (T5 Gra Rin), then HALT with Run=0. Start and Stop in the same cycle → T0 next.
- opcode=5'b10101:
  - Without the macro: nop, next T0.
  - With LDST_ILLEGAL_TRAP_EN: HALT with illegal=1, which clears on Start.
